i2s_tx_fifo: RTL and testbench
==============================

Name: i2s_tx_fifo

Overview:
- Stereo sample buffer directly upstream of the I2S master transmitter.
- Accepts 32-bit words from the APB register side as left/right pairs and stores up to DEPTH pairs.
- Presents one pair on o_data_left/o_data_right; advances to the next pair on each transmitter data request pulse.
- Reports fill level, full/empty and a sticky underrun flag to the APB status logic.

Parameters:
DEPTH, 8, number of stereo pairs stored; power of two, minimum 2
AW, $clog2(DEPTH), pointer index width (derived, not overridden)
THRESHOLD, 2, low-water level used by the optional IRQ

Ports:
i_clk  input  1  system clock
i_nrst  input  1  reset, asynchronous, active-low
i_enable  input  1  read side enable; i_data_rqst ignored when low
i_clear  input  1  synchronous flush, single-cycle pulse
i_wr_valid  input  1  write word strobe from APB side
i_wr_data  input  32  write word; alternates left, right, left, ...
o_wr_ready  output  1  word accepted when i_wr_valid && o_wr_ready
i_data_rqst  input  1  one-cycle pop request from transmitter
o_data_left  output  32  current left sample to transmitter
o_data_right  output  32  current right sample to transmitter
o_level  output  AW+1  stored pairs, 0..DEPTH
o_full  output  1  o_level == DEPTH
o_empty  output  1  o_level == 0
o_underrun  output  1  sticky: request arrived while empty
i_underrun_clr  input  1  clears o_underrun

Behaviour:
- Reset: pointers, level, write state, o_data_left/right = 0; o_underrun = 0; o_empty = 1; o_full = 0; o_wr_ready = 1.
- Storage: DEPTH x 64-bit array {left, right}; write/read pointers AW+1 bits, natural wrap; full = MSBs differ and indices equal; empty = pointers equal.
- Write FSM, two states:
  - W_LEFT: accepted word goes to 32-bit staging register; move to W_RIGHT.
  - W_RIGHT: accepted word commits {staging, word} at write pointer; pointer +1; return to W_LEFT.
  - o_wr_ready = !o_full in both states. Level counts committed pairs only; a staged left word is invisible to the read side.
- Read side:
  - On i_enable && i_data_rqst && !o_empty: next cycle o_data_left/right take the head pair; read pointer +1.
  - Outputs are registered and held stable between requests.
  - Latency: 1 clock from rqst to new data. The transmitter loads on the following tclk falling edge, well later.
- Underrun:
  - Request while empty: outputs forced to 0 next cycle; pointer unchanged; o_underrun set.
  - Commit and request in the same cycle with FIFO empty: counts as underrun, no bypass; committed pair is stored.
- Simultaneous commit and pop when non-empty: level unchanged; both pointers advance.
- Request while i_enable low: ignored; outputs held; no underrun.
- o_underrun:
  - Cleared by i_underrun_clr.
  - Set wins over clear in the same cycle.
- i_clear:
  - Zeroes pointers, level and outputs; returns write FSM to W_LEFT, discarding the staged word; clears o_underrun.
  - Any write or request in the same cycle is dropped.
- Async reset mid-operation: immediate return to reset state; no partial pair survives.

Optional Feature:
Macro I2S_TXFIFO_IRQ_EN.
- Defined: extra output o_irq (1 bit, registered, reset 0).
  - o_irq = 1 while o_level <= THRESHOLD and i_enable = 1, otherwise 0.
  - Level-sensitive, updates one cycle after level changes.
- Not defined: port and logic absent. Software polls o_level.

Test Plan:
- Reset then write 0x11111111, 0x22222222, then rqst -> next cycle o_data_left=0x11111111, o_data_right=0x22222222; o_level 1->0; o_empty=1.
- Write 16 words (8 pairs) -> o_full=1, o_wr_ready=0. 17th word not accepted. Eight rqsts return pairs in order with no corruption across pointer wrap.
- Empty FIFO, rqst -> outputs 0x0, o_underrun=1. Pulse i_underrun_clr -> 0. Same-cycle set and clear -> stays 1.
- Write left only, then i_clear, then write 0xA, 0xB, rqst -> pair (0xA, 0xB); the old staged word is discarded.
- Level 3, simultaneous commit and rqst -> level stays 3; output is the oldest pair. i_enable=0 with rqst -> no pop, no underrun.
- I2S_TXFIFO_IRQ_EN, THRESHOLD=2: fill to 4, pop to 2 -> o_irq rises one cycle after level reaches 2. Deassert i_enable -> o_irq=0.

Source files
------------

// File: rtl/i2s_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// i2s_tx_fifo_if
// Bus bundle for the I2S transmit FIFO: the APB-side write handshake and the
// transmitter-side request/data pair.
//
// Handshake semantics:
//   write : a word transfers on a clock edge where i_wr_valid && o_wr_ready;
//           i_wr_data must be stable while i_wr_valid is high. Words alternate
//           left, right, left, ...
//   read  : i_data_rqst is a one-cycle pop pulse. There is no ready. The
//           o_data_left/o_data_right pair updates one clock after the pulse and
//           holds until the next accepted pulse.
//
// Signals:
//   i_wr_valid   write word strobe            (master -> fifo)
//   i_wr_data    32-bit write word            (master -> fifo)
//   o_wr_ready   fifo can take a word         (fifo -> master)
//   i_data_rqst  transmitter pop pulse        (master -> fifo)
//   o_data_left  current left sample          (fifo -> master)
//   o_data_right current right sample         (fifo -> master)
// -----------------------------------------------------------------------------
interface i2s_tx_fifo_if;
  logic        i_wr_valid;
  logic [31:0] i_wr_data;
  logic        o_wr_ready;
  logic        i_data_rqst;
  logic [31:0] o_data_left;
  logic [31:0] o_data_right;

  modport master (
    output i_wr_valid, i_wr_data, i_data_rqst,
    input  o_wr_ready, o_data_left, o_data_right
  );

  modport slave (
    input  i_wr_valid, i_wr_data, i_data_rqst,
    output o_wr_ready, o_data_left, o_data_right
  );
endinterface

// File: rtl/i2s_tx_fifo.sv
// -----------------------------------------------------------------------------
// i2s_tx_fifo
// Stereo sample buffer in front of the I2S master transmitter. 32-bit words
// arrive as left/right pairs; up to DEPTH complete pairs are stored. The
// transmitter pops one pair per request pulse and sees it on registered
// outputs one clock later.
//
// Ports:
//   i_clk           system clock
//   i_nrst          asynchronous active-low reset
//   i_enable        read side enable; requests ignored while low
//   i_clear         synchronous flush pulse
//   i_underrun_clr  clears the sticky underrun flag
//   bus             i2s_tx_fifo_if.slave: write handshake + request/data pair
//   o_level         stored pairs, 0..DEPTH
//   o_full/o_empty  level == DEPTH / level == 0
//   o_underrun      sticky: request arrived while empty
//   o_dbg_wr_state  write FSM state (0 = W_LEFT, 1 = W_RIGHT)
//   o_irq           only with I2S_TXFIFO_IRQ_EN: level <= THRESHOLD while enabled
//
// Optional feature macro: I2S_TXFIFO_IRQ_EN
// -----------------------------------------------------------------------------
module i2s_tx_fifo #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned THRESHOLD = 2,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_nrst,
  input  logic          i_enable,
  input  logic          i_clear,
  input  logic          i_underrun_clr,
  i2s_tx_fifo_if.slave  bus,
  output logic [AW:0]   o_level,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_underrun,
  output logic          o_dbg_wr_state
`ifdef I2S_TXFIFO_IRQ_EN
  ,
  output logic          o_irq
`endif
);

  localparam logic [0:0] W_LEFT  = 1'b0;
  localparam logic [0:0] W_RIGHT = 1'b1;

  logic [63:0] mem [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [0:0]  wr_state_q, wr_state_d;
  logic [31:0] stage_q, stage_d;
  logic [31:0] left_q, left_d;
  logic [31:0] right_q, right_d;
  logic        underrun_q, underrun_d;

  logic        full, empty, wr_ready;
  logic        wr_fire, commit, pop_req, pop, under;
  logic [AW:0] level;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_ready = !full;

  assign wr_fire = bus.i_wr_valid && wr_ready && !i_clear;
  assign commit  = wr_fire && (wr_state_q == W_RIGHT);
  assign pop_req = i_enable && bus.i_data_rqst && !i_clear;
  // Emptiness is judged before this cycle's commit: no bypass of a pair that
  // is being written in the same cycle.
  assign pop     = pop_req && !empty;
  assign under   = pop_req && empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_state_d = wr_state_q;
    stage_d    = stage_q;
    left_d     = left_q;
    right_d    = right_q;
    underrun_d = underrun_q;
    if (i_clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      wr_state_d = W_LEFT;
      stage_d    = '0;
      left_d     = '0;
      right_d    = '0;
      underrun_d = 1'b0;
    end else begin
      if (wr_fire) begin
        if (wr_state_q == W_LEFT) begin
          stage_d    = bus.i_wr_data;
          wr_state_d = W_RIGHT;
        end else begin
          wr_ptr_d   = wr_ptr_q + 1'b1;
          wr_state_d = W_LEFT;
        end
      end
      if (pop) begin
        {left_d, right_d} = mem[rd_ptr_q[AW-1:0]];
        rd_ptr_d          = rd_ptr_q + 1'b1;
      end else if (under) begin
        left_d  = '0;
        right_d = '0;
      end
      // A new underrun event takes priority over a same-cycle clear.
      if (under) begin
        underrun_d = 1'b1;
      end else if (i_underrun_clr) begin
        underrun_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_state_q <= W_LEFT;
      stage_q    <= '0;
      left_q     <= '0;
      right_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_state_q <= wr_state_d;
      stage_q    <= stage_d;
      left_q     <= left_d;
      right_q    <= right_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage array needs no reset: only slots behind the write pointer are read.
  always_ff @(posedge i_clk) begin
    if (commit) begin
      mem[wr_ptr_q[AW-1:0]] <= {stage_q, bus.i_wr_data};
    end
  end

`ifdef I2S_TXFIFO_IRQ_EN
  localparam logic [AW:0] THR_L = (AW+1)'(THRESHOLD);
  logic irq_q;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (level <= THR_L) && i_enable;
    end
  end

  assign o_irq = irq_q;
`endif

  assign bus.o_wr_ready   = wr_ready;
  assign bus.o_data_left  = left_q;
  assign bus.o_data_right = right_q;
  assign o_level          = level;
  assign o_full           = full;
  assign o_empty          = empty;
  assign o_underrun       = underrun_q;
  assign o_dbg_wr_state   = wr_state_q;

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx_fifo
// Bench for i2s_tx_fifo: directed vector table, hand-written corner
// sequences, then randomized traffic, all against a queue-based reference.
// -----------------------------------------------------------------------------
module tb_i2s_tx_fifo;
  localparam int DEPTH     = 8;
  localparam int THRESHOLD = 2;
  localparam int AW        = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic          enable, clear, uclr;
  logic [AW:0]   level;
  logic          full, empty, underrun, dbg;
`ifdef I2S_TXFIFO_IRQ_EN
  logic          irq;
`endif

  i2s_tx_fifo_if bus();

  i2s_tx_fifo #(.DEPTH(DEPTH), .THRESHOLD(THRESHOLD)) dut (
    .i_clk          (clk),
    .i_nrst         (nrst),
    .i_enable       (enable),
    .i_clear        (clear),
    .i_underrun_clr (uclr),
    .bus            (bus.slave),
    .o_level        (level),
    .o_full         (full),
    .o_empty        (empty),
    .o_underrun     (underrun),
    .o_dbg_wr_state (dbg)
`ifdef I2S_TXFIFO_IRQ_EN
    ,
    .o_irq          (irq)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [63:0] exp_q[$];
  logic        m_staged;
  logic [31:0] m_stage, m_left, m_right;
  logic        m_under, m_irq;

  task automatic model_reset();
    exp_q.delete();
    m_staged = 1'b0;
    m_stage  = '0;
    m_left   = '0;
    m_right  = '0;
    m_under  = 1'b0;
    m_irq    = 1'b0;
  endtask

  task automatic model_step(input logic wv, input logic [31:0] wd, input logic rq,
                            input logic en, input logic cl, input logic uc);
    int sz = exp_q.size();
    logic [63:0] head;
    m_irq = (sz <= THRESHOLD) && en;
    if (cl) begin
      exp_q.delete();
      m_staged = 1'b0;
      m_left   = '0;
      m_right  = '0;
      m_under  = 1'b0;
    end else begin
      if (en && rq) begin
        if (sz > 0) begin
          head    = exp_q.pop_front();
          m_left  = head[63:32];
          m_right = head[31:0];
        end else begin
          m_left  = '0;
          m_right = '0;
        end
      end
      if (en && rq && sz == 0) m_under = 1'b1;
      else if (uc)             m_under = 1'b0;
      if (wv && sz < DEPTH) begin
        if (!m_staged) begin
          m_stage  = wd;
          m_staged = 1'b1;
        end else begin
          exp_q.push_back({m_stage, wd});
          m_staged = 1'b0;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_model(input string tag);
    int sz = exp_q.size();
    logic [AW:0] e_lvl;
    logic [72:0] act, exp;
    e_lvl = sz[AW:0];
    act = {level, full, empty, bus.o_wr_ready, underrun, dbg, bus.o_data_left, bus.o_data_right};
    exp = {e_lvl, (sz == DEPTH), (sz == 0), (sz < DEPTH), m_under, m_staged, m_left, m_right};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL model %s: got lvl/full/empty/rdy/unr/st/l/r=%h expected %h", tag, act, exp);
    end
`ifdef I2S_TXFIFO_IRQ_EN
    n_vec++;
    if (irq !== m_irq) begin
      n_err++;
      $display("FAIL irq %s: got %b expected %b", tag, irq, m_irq);
    end
`endif
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic wv, input logic [31:0] wd, input logic rq,
                      input logic en, input logic cl, input logic uc, input string tag);
    @(negedge clk);
    bus.i_wr_valid  = wv;
    bus.i_wr_data   = wd;
    bus.i_data_rqst = rq;
    enable          = en;
    clear           = cl;
    uclr            = uc;
    model_step(wv, wd, rq, en, cl, uc);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        wv;
    logic [31:0] wd;
    logic        rq, en, cl, uc;
    logic [AW:0] lvl;
    logic [31:0] l, r;
    logic        un, em;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  initial begin
    logic [69:0] va, ve;
    // inputs: wv wd rq en cl uc | expected after edge: level left right underrun empty
    tbl[0]  = '{1'b1, 32'h11111111, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,        32'h0,        1'b0, 1'b1};
    tbl[1]  = '{1'b1, 32'h22222222, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h11111111, 32'h22222222, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,        32'h0,        1'b1, 1'b1};
    tbl[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0,        32'h0,        1'b0, 1'b1};
    tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0,        32'h0,        1'b1, 1'b1};
    tbl[6]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0,        32'h0,        1'b0, 1'b1};
    tbl[7]  = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,        32'h0,        1'b0, 1'b1};
    tbl[8]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0,        32'h0,        1'b0, 1'b1};
    tbl[9]  = '{1'b1, 32'h0000000A, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,        32'h0,        1'b0, 1'b1};
    tbl[10] = '{1'b1, 32'h0000000B, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0000000A, 32'h0000000B, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0000000A, 32'h0000000B, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 32'h0000000C, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0,        32'h0,        1'b0, 1'b1};
    tbl[14] = '{1'b1, 32'h0000000D, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,        32'h0,        1'b0, 1'b1};
    tbl[15] = '{1'b1, 32'h0000000E, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[16] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0000000D, 32'h0000000E, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0000000D, 32'h0000000E, 1'b0, 1'b1};
    tbl[18] = '{1'b1, 32'h00000002, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 32'h0,        32'h0,        1'b1, 1'b0};
    tbl[19] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h00000001, 32'h00000002, 1'b1, 1'b1};
    tbl[20] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h00000001, 32'h00000002, 1'b0, 1'b1};

    // ---- reset ----
    nrst = 1'b0;
    bus.i_wr_valid = 1'b0; bus.i_wr_data = '0; bus.i_data_rqst = 1'b0;
    enable = 1'b1; clear = 1'b0; uclr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    check("reset_ready_empty", {62'd0, bus.o_wr_ready, empty}, 64'h3);
    @(negedge clk);
    nrst = 1'b1;

    // ---- table ----
    for (int i = 0; i < NV; i++) begin
      step(tbl[i].wv, tbl[i].wd, tbl[i].rq, tbl[i].en, tbl[i].cl, tbl[i].uc, $sformatf("tbl%0d", i));
      va = {level, bus.o_data_left, bus.o_data_right, underrun, empty};
      ve = {tbl[i].lvl, tbl[i].l, tbl[i].r, tbl[i].un, tbl[i].em};
      n_vec++;
      if (va !== ve) begin
        n_err++;
        $display("FAIL vec%0d: got lvl/l/r/unr/empty=%h expected %h", i, va, ve);
      end
    end

    // ---- fill to full, overflow attempt, drain across pointer wrap ----
    for (int i = 0; i < 17; i++) step(1'b1, 32'h1000_0000 + i, 1'b0, 1'b1, 1'b0, 1'b0, "fill");
    check("full_flags", {59'd0, level, full, bus.o_wr_ready}, {59'd0, 4'd8, 1'b1, 1'b0});
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, "drain");
      check($sformatf("drain%0d", i), {bus.o_data_left, bus.o_data_right},
            {32'h1000_0000 + 2*i, 32'h1000_0000 + 2*i + 1});
    end
    check("drained_empty", {63'd0, empty}, 64'd1);

    // ---- simultaneous commit and pop at level 3; request while disabled ----
    for (int i = 0; i < 7; i++) step(1'b1, 32'h2000_0000 + i, 1'b0, 1'b1, 1'b0, 1'b0, "lvl3");
    step(1'b1, 32'h2000_0007, 1'b1, 1'b1, 1'b0, 1'b0, "commit_pop");
    check("commit_pop_lvl", {60'd0, level}, 64'd3);
    check("commit_pop_data", {bus.o_data_left, bus.o_data_right}, 64'h2000_0000_2000_0001);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, "disabled_rqst");
    check("disabled_rqst", {59'd0, level, underrun}, {59'd0, 4'd3, 1'b0});
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, "drain3");

    // ---- asynchronous reset with a pair stored and a left word staged ----
    for (int i = 0; i < 5; i++) step(1'b1, 32'h3000_0000 + i, 1'b0, 1'b1, 1'b0, 1'b0, "pre_rst");
    @(negedge clk);
    bus.i_wr_valid = 1'b0;
    #2;
    nrst = 1'b0;
    #1;
    model_reset();
    check("async_rst", {57'd0, level, empty, dbg, underrun}, {57'd0, 4'd0, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    nrst = 1'b1;
    step(1'b1, 32'h4000_0000, 1'b0, 1'b1, 1'b0, 1'b0, "post_rst");
    step(1'b1, 32'h4000_0001, 1'b0, 1'b1, 1'b0, 1'b0, "post_rst");
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, "post_rst_pop");
    check("post_rst_pair", {bus.o_data_left, bus.o_data_right}, 64'h4000_0000_4000_0001);

`ifdef I2S_TXFIFO_IRQ_EN
    // ---- low-water IRQ: fill to 4, pop to 2, then disable ----
    for (int i = 0; i < 8; i++) step(1'b1, 32'h5000_0000 + i, 1'b0, 1'b1, 1'b0, 1'b0, "irq_fill");
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, "irq_pop");
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, "irq_pop");
    check("irq_lag", {59'd0, level, irq}, {59'd0, 4'd2, 1'b0});
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, "irq_rise");
    check("irq_rise", {63'd0, irq}, 64'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, "irq_dis");
    check("irq_dis", {63'd0, irq}, 64'd0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, "irq_drain");
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, "irq_drain");
`endif

    // ---- randomized traffic against the reference ----
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 90, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 5, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
